// File: rtl/policy_table_loader.sv
// policy_table_loader
// Writer side of the paddle-AI policy ROM. It takes a host-link byte stream,
// waits for a sync header, and then unpacks each payload byte LSB-first into
// four 2-bit action entries. The entries are written to consecutive addresses
// of the policy memory. After DEPTH entries it checks a trailing XOR checksum
// and reports done or err.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// While in_valid is high and in_ready is low, the source holds in_data stable.
// in_ready is a combinational function of registered state only, so the
// source never sees a combinational path from in_valid back to in_ready.
module policy_table_loader #(
  parameter int          ADDR_W    = 16,
  parameter int          DEPTH     = 59049,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] entries_written
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2
  } state_t;

  // Address of the final entry; the write landing here ends the payload.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t      state;
  logic [7:0]  checksum;
  // Upper entries of the current byte that have not been written yet.
  logic [5:0]  rest;
  // Number of entries of the current byte still to be written after the
  // write that is presented this cycle.
  logic [1:0]  pending;

  logic        accept;
  logic        issue;
  logic [1:0]  entry;

  // Ready whenever no entries are queued. In LOAD that covers the cycle that
  // presents a byte's final write, so a new byte lands with no bubble.
  always_comb begin
    in_ready = (state != LOAD) || (pending == 2'd0);
  end

  // A write is issued either from queued entries or from a freshly accepted
  // byte (whose entry 0 goes out straight away).
  always_comb begin
    accept = in_valid && in_ready;
    issue  = 1'b0;
    entry  = in_data[1:0];
    if (state == LOAD) begin
      if (pending != 2'd0) begin
        issue = 1'b1;
        entry = rest[1:0];
      end else if (in_valid) begin
        issue = 1'b1;
        entry = in_data[1:0];
      end
    end
  end

  // Main control: state, checksum, unpacking and the registered memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      checksum        <= 8'h00;
      rest            <= 6'd0;
      pending         <= 2'd0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= 2'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      entries_written <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            checksum        <= 8'h00;
            entries_written <= '0;
            pending         <= 2'd0;
            rest            <= 6'd0;
            done            <= 1'b0;
            err             <= 1'b0;
            busy            <= 1'b1;
            state           <= LOAD;
          end
        end

        LOAD: begin
          if (pending != 2'd0) begin
            rest    <= {2'b00, rest[5:2]};
            pending <= pending - 2'd1;
          end else if (in_valid) begin
            checksum <= checksum ^ in_data;
            rest     <= in_data[7:2];
            pending  <= 2'd3;
          end
          if (issue) begin
            mem_we          <= 1'b1;
            mem_addr        <= entries_written;
            mem_din         <= entry;
            entries_written <= entries_written + ADDR_W'(1);
            // Final entry: drop whatever is left of this byte (it is
            // already folded into the checksum) and await the checksum.
            if (entries_written == LAST_ADDR) begin
              pending <= 2'd0;
              rest    <= 6'd0;
              state   <= CHK;
            end
          end
        end

        CHK: begin
          if (accept) begin
            if (in_data == checksum) begin
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_policy_table_loader.sv
// Testbench for policy_table_loader. It drives two instances: a small one
// (DEPTH=6) for directed cases and one with the default DEPTH for the
// full-size load. A queue of expected writes comes from the unpacking rule,
// and a negedge process checks every write against it.
module tb_policy_table_loader;

  localparam int AW = 16;
  localparam int DS = 6;
  localparam int DL = 59049;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic [7:0]    s_data = 8'h00, l_data = 8'h00;
  logic          s_valid = 1'b0, l_valid = 1'b0;
  logic          s_ready, l_ready;
  logic          s_we, l_we;
  logic [AW-1:0] s_addr, l_addr;
  logic [1:0]    s_din, l_din;
  logic          s_busy, l_busy, s_done, l_done, s_err, l_err;
  logic [AW-1:0] s_ew, l_ew;

  policy_table_loader #(.ADDR_W(AW), .DEPTH(DS), .SYNC_BYTE(8'hA5)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .mem_we(s_we), .mem_addr(s_addr), .mem_din(s_din),
    .busy(s_busy), .done(s_done), .err(s_err), .entries_written(s_ew)
  );

  policy_table_loader #(.ADDR_W(AW)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_data(l_data), .in_valid(l_valid),
    .in_ready(l_ready), .mem_we(l_we), .mem_addr(l_addr), .mem_din(l_din),
    .busy(l_busy), .done(l_done), .err(l_err), .entries_written(l_ew)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] pay[];

  // Entry i of the payload: byte i/4, bit pair i%4, LSB first.
  function automatic logic [1:0] entry_of(input int i);
    logic [7:0] b;
    b = pay[i / 4] >> (2 * (i % 4));
    return b[1:0];
  endfunction

  function automatic logic [7:0] xor_of();
    logic [7:0] x;
    x = 8'h00;
    foreach (pay[i]) x = x ^ pay[i];
    return x;
  endfunction

  logic [AW+1:0] exp_q_s[$];
  logic [AW+1:0] exp_q_l[$];

  task automatic push_expected(input int which);
    int depth;
    depth = (which != 0) ? DL : DS;
    for (int i = 0; i < depth; i++) begin
      if (which != 0) exp_q_l.push_back({AW'(i), entry_of(i)});
      else            exp_q_s.push_back({AW'(i), entry_of(i)});
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [1:0]    mem_s [DS];
  logic [1:0]    mem_l [DL];
  int            wr_s = 0, wr_l = 0, runs_s = 0, runs_l = 0, low_s = 0, low_l = 0;
  logic          prev_we_s = 1'b0, prev_we_l = 1'b0;
  logic [AW-1:0] last_addr_l = '0;
  logic [AW+1:0] e_s, e_l;

  // Check every write on both instances against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_err_exclusive_s", {s_done, s_err} == 2'b11, 1'b0);
      check("done_err_exclusive_l", {l_done, l_err} == 2'b11, 1'b0);
      if (s_we) begin
        wr_s++;
        if (!prev_we_s) runs_s++;
        if (!s_ready) low_s++;
        if (exp_q_s.size() == 0) check("unexpected_write_s", s_addr, 64'hFFFF_FFFF);
        else begin
          e_s = exp_q_s.pop_front();
          check("addr_s", s_addr, e_s[AW+1:2]);
          check("din_s", s_din, e_s[1:0]);
        end
        if (s_addr < AW'(DS)) mem_s[s_addr] = s_din;
        else check("addr_range_s", s_addr, DS - 1);
      end
      if (l_we) begin
        wr_l++;
        if (!prev_we_l) runs_l++;
        if (!l_ready) low_l++;
        last_addr_l = l_addr;
        if (exp_q_l.size() == 0) check("unexpected_write_l", l_addr, 64'hFFFF_FFFF);
        else begin
          e_l = exp_q_l.pop_front();
          check("addr_l", l_addr, e_l[AW+1:2]);
          check("din_l", l_din, e_l[1:0]);
        end
        if (l_addr < AW'(DL)) mem_l[l_addr] = l_din;
        else check("addr_range_l", l_addr, DL - 1);
      end
      prev_we_s = s_we;
      prev_we_l = l_we;
    end else begin
      prev_we_s = 1'b0;
      prev_we_l = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Present a byte from a negedge and return at the posedge where it transfers.
  task automatic send(input int which, input logic [7:0] b);
    int n;
    @(negedge clk);
    if (which != 0) begin l_data = b; l_valid = 1'b1; end
    else            begin s_data = b; s_valid = 1'b1; end
    n = 0;
    while (!((which != 0) ? l_ready : s_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check("ready_timeout", n, 0);
      if (which != 0) l_valid = 1'b0; else s_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which != 0) l_valid = 1'b0; else s_valid = 1'b0;
    end
  endtask

  // Full load of pay[]: sync, payload (gap idle cycles between bytes), checksum.
  task automatic run_load(input int which, input int gap, input logic [7:0] chk_byte,
                          input logic exp_good, output int dw, output int dr, output int dlow);
    int w0, r0, lo0, depth;
    depth = (which != 0) ? DL : DS;
    push_expected(which);
    w0  = (which != 0) ? wr_l : wr_s;
    r0  = (which != 0) ? runs_l : runs_s;
    lo0 = (which != 0) ? low_l : low_s;
    send(which, 8'hA5);
    idle(which, 1);
    #1;
    check("sync_busy",  (which != 0) ? l_busy : s_busy, 1'b1);
    check("sync_done",  (which != 0) ? l_done : s_done, 1'b0);
    check("sync_err",   (which != 0) ? l_err  : s_err,  1'b0);
    check("sync_count", (which != 0) ? l_ew   : s_ew,   0);
    foreach (pay[i]) begin
      send(which, pay[i]);
      if (gap > 0) idle(which, gap);
    end
    send(which, chk_byte);
    idle(which, 1);
    #1;
    check("end_busy",  (which != 0) ? l_busy : s_busy, 1'b0);
    check("end_done",  (which != 0) ? l_done : s_done, exp_good);
    check("end_err",   (which != 0) ? l_err  : s_err,  !exp_good);
    check("end_count", (which != 0) ? l_ew   : s_ew,   depth);
    check("end_queue_empty", (which != 0) ? exp_q_l.size() : exp_q_s.size(), 0);
    dw   = ((which != 0) ? wr_l : wr_s) - w0;
    dr   = ((which != 0) ? runs_l : runs_s) - r0;
    dlow = ((which != 0) ? low_l : low_s) - lo0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dw, dr, dlow, n, w0, bad;
    logic [11:0] pk;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready_s", s_ready, 1'b1); check("rst_we_s", s_we, 1'b0);
    check("rst_addr_s", s_addr, 0);      check("rst_din_s", s_din, 0);
    check("rst_busy_s", s_busy, 1'b0);   check("rst_done_s", s_done, 1'b0);
    check("rst_err_s", s_err, 1'b0);     check("rst_count_s", s_ew, 0);
    check("rst_ready_l", l_ready, 1'b1); check("rst_we_l", l_we, 1'b0);
    check("rst_busy_l", l_busy, 1'b0);   check("rst_count_l", l_ew, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the model with hand-computed values: 1B,0E -> 3,2,1,0,2,3 ; xor 15
    pay = new[2];
    pay[0] = 8'h1B;
    pay[1] = 8'h0E;
    pk = '0;
    for (int i = 0; i < DS; i++) pk[2*i +: 2] = entry_of(i);
    check("model_entries", pk, 12'hE1B);
    check("model_checksum", xor_of(), 8'h15);

    // Good load with idle gaps between bytes
    run_load(0, 2, 8'h15, 1'b1, dw, dr, dlow);
    check("t1_writes", dw, 6);
    pk = '0;
    for (int i = 0; i < DS; i++) pk[2*i +: 2] = mem_s[i];
    check("t1_memory", pk, 12'hE1B);

    // Same stream, wrong checksum
    run_load(0, 2, 8'h00, 1'b0, dw, dr, dlow);
    check("t2_writes", dw, 6);

    // Non-sync bytes in IDLE are discarded
    send(0, 8'h00);
    send(0, 8'hFF);
    idle(0, 3);
    #1;
    check("t3_idle_busy", s_busy, 1'b0);
    check("t3_idle_err_held", s_err, 1'b1);
    check("t3_idle_count_held", s_ew, 6);
    run_load(0, 1, 8'h15, 1'b1, dw, dr, dlow);
    check("t3_writes", dw, 6);

    // Back-to-back payload: one unbroken write burst, ready low 4 times
    run_load(0, 0, 8'h15, 1'b1, dw, dr, dlow);
    check("t4_writes", dw, 6);
    check("t4_bursts", dr, 1);
    check("t4_ready_low", dlow, 4);

    // Reset after three writes, then a fresh load from address 0
    push_expected(0);
    w0 = wr_s;
    send(0, 8'hA5);
    idle(0, 1);
    send(0, 8'h1B);
    idle(0, 1);
    n = 0;
    while (wr_s < w0 + 3 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_three_writes", wr_s - w0, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_we", s_we, 1'b0);
    check("t5_rst_busy", s_busy, 1'b0);
    check("t5_rst_count", s_ew, 0);
    check("t5_rst_ready", s_ready, 1'b1);
    exp_q_s.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_load(0, 0, 8'h15, 1'b1, dw, dr, dlow);
    check("t5_writes", dw, 6);

    // Full-size load with random payload and correct checksum
    pay = new[14763];
    foreach (pay[i]) pay[i] = 8'($urandom_range(0, 255));
    run_load(1, 0, xor_of(), 1'b1, dw, dr, dlow);
    check("t6_writes", dw, 59049);
    check("t6_bursts", dr, 1);
    check("t6_ready_low", dlow, 44286);
    check("t6_last_addr", last_addr_l, 59048);
    bad = 0;
    for (int i = 0; i < DL; i++) if (mem_l[i] !== entry_of(i)) bad++;
    check("t6_memory_scoreboard", bad, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
